// File: rtl/playfield_pixel_shifter_pkg.sv
// Shared graphics definitions for the playfield pixel path.
package playfield_pixel_shifter_pkg;

  localparam int PF_NPLANES = 4;
  localparam int PF_CBITS   = 4;

  // {colour, pixel index} width for the default configuration
  localparam int PFPIX_W = PF_CBITS + PF_NPLANES;

  // Last phase of an 8-pixel tile row; the shifter reloads after it
  localparam logic [2:0] PHASE_WRAP = 3'd7;

  // One tile row: plane p in bits [8p+7:8p], leftmost pixel in the MSB
  typedef logic [8*PF_NPLANES-1:0] tile_row_t;
  typedef logic [PFPIX_W-1:0]      pfpix_t;

  // PFPIX width for a non-default plane/colour configuration
  function automatic int pfpix_width(input int nplanes, input int cbits);
    return nplanes + cbits;
  endfunction

endpackage

// File: rtl/playfield_pixel_shifter_if.sv
// Tile-fetch side and pixel-output side of the playfield shifter.
interface playfield_pixel_shifter_if
  import playfield_pixel_shifter_pkg::*;
#(
  parameter int NPLANES = PF_NPLANES,
  parameter int CBITS   = PF_CBITS
);

  logic                      PFHST_b;
  logic [2:0]                HFINE;
  logic                      GFX_LD;
  logic [8*NPLANES-1:0]      GFX_D;
  logic [CBITS-1:0]          COLOR;
  logic [CBITS+NPLANES-1:0]  PFPIX;
  logic                      PF_TRANS;

  // Video timing / tile fetch logic drives the strobes and data
  modport master (
    output PFHST_b, HFINE, GFX_LD, GFX_D, COLOR,
    input  PFPIX, PF_TRANS
  );

  // The shifter consumes tile data and produces pixels
  modport slave (
    input  PFHST_b, HFINE, GFX_LD, GFX_D, COLOR,
    output PFPIX, PF_TRANS
  );

endinterface

// File: rtl/playfield_pixel_shifter_plane.sv
// One bitplane: 8-bit parallel-load shift register, MSB is the current pixel.
module pf_plane_shift (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_msb
);

  logic [7:0] r_sr;

  // Load a new row or shift left, filling with transparent zeros
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst)       r_sr <= '0;
    else if (i_load) r_sr <= i_data;
    else             r_sr <= {r_sr[6:0], 1'b0};
  end

  assign o_msb = r_sr[7];

endmodule

// File: rtl/playfield_pixel_shifter.sv
// Playfield pixel shifter: hold register, per-plane shifters, fine-scroll delay line.
module playfield_pixel_shifter
  import playfield_pixel_shifter_pkg::*;
#(
  parameter int NPLANES = PF_NPLANES,
  parameter int CBITS   = PF_CBITS
) (
  input  logic                        MCKR,
  input  logic                        rst,
  playfield_pixel_shifter_if.slave    pf
);

  localparam int PW = pfpix_width(NPLANES, CBITS);

  logic [2:0]            r_phase;
  logic [8*NPLANES-1:0]  r_hold_d;
  logic [CBITS-1:0]      r_hold_c;
  logic [CBITS-1:0]      r_sh_col;
  logic [2:0]            r_hfine_l;
  logic [PW-1:0]         r_dly [8];
  logic [PW-1:0]         r_pfpix;
  logic                  r_pf_trans;

  logic                  w_load;
  logic [NPLANES-1:0]    w_idx;
  logic [PW-1:0]         w_shout;
  logic [PW-1:0]         w_tap;

  // A line start abandons the current tile and reloads at once
  assign w_load  = (r_phase == PHASE_WRAP) || !pf.PFHST_b;
  assign w_shout = {r_sh_col, w_idx};
  assign w_tap   = r_dly[r_hfine_l];

  // Pixel phase within the tile row; line start realigns it to 0
  always_ff @(posedge MCKR) begin
    if (rst)              r_phase <= '0;
    else if (!pf.PFHST_b) r_phase <= '0;
    else                  r_phase <= r_phase + 3'd1;
  end

  // Hold register: on a load/capture collision the shifter takes the old row
  always_ff @(posedge MCKR) begin
    if (rst) begin
      r_hold_d <= '0;
      r_hold_c <= '0;
    end else if (pf.GFX_LD) begin
      r_hold_d <= pf.GFX_D;
      r_hold_c <= pf.COLOR;
    end
  end

  // Colour travels with the row it was loaded alongside
  always_ff @(posedge MCKR) begin
    if (rst)         r_sh_col <= '0;
    else if (w_load) r_sh_col <= r_hold_c;
  end

  genvar p;
  for (p = 0; p < NPLANES; p++) begin : g_plane
    pf_plane_shift u_plane (
      .i_clk  (MCKR),
      .i_rst  (rst),
      .i_load (w_load),
      .i_data (r_hold_d[8*p +: 8]),
      .o_msb  (w_idx[p])
    );
  end

  // Fine scroll is latched only at line start so it cannot change mid-line
  always_ff @(posedge MCKR) begin
    if (rst)              r_hfine_l <= '0;
    else if (!pf.PFHST_b) r_hfine_l <= pf.HFINE;
  end

  // Delay line advancing every cycle, entry 0 fed from the shifter
  always_ff @(posedge MCKR) begin
    // NOTE: the delay entries are cleared on reset so no stale pixel leaks out after it; this is a small register array, not a RAM.
    if (rst) begin
      r_dly <= '{default: '0};
    end else begin
      r_dly[0] <= w_shout;
      for (int i = 1; i < 8; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Output stage: pixel and transparency flag from the same scrolled tap
  always_ff @(posedge MCKR) begin
    if (rst) begin
      r_pfpix    <= '0;
      r_pf_trans <= 1'b1;
    end else begin
      r_pfpix    <= w_tap;
      r_pf_trans <= (w_tap[NPLANES-1:0] == '0);
    end
  end

  assign pf.PFPIX    = r_pfpix;
  assign pf.PF_TRANS = r_pf_trans;

endmodule

// File: tb/tb_playfield_pixel_shifter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a tile/pixel model.
module tb_playfield_pixel_shifter;
  import playfield_pixel_shifter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  playfield_pixel_shifter_if #(.NPLANES(4), .CBITS(4)) pf_if ();

  playfield_pixel_shifter #(.NPLANES(4), .CBITS(4)) dut (
    .MCKR (clk),
    .rst  (rst),
    .pf   (pf_if)
  );

  // ---------------- reference model ----------------
  typedef struct {
    tile_row_t  d;
    logic [3:0] c;
  } tile_t;

  tile_t      m_pend;      // last captured tile row
  tile_t      m_show;      // row currently being displayed
  int         m_pos;       // pixel position within the displayed row
  int         m_h;         // latched fine scroll
  logic [7:0] m_hist[$];   // m_hist[k] = shifter pixel from k+1 cycles ago
  logic [7:0] exp_pfpix;
  logic       exp_trans;

  function automatic logic [7:0] pix_of(input tile_t t, input int pos);
    logic [3:0] idx;
    for (int p = 0; p < 4; p++) idx[p] = t.d[8*p + 7 - pos];
    return {t.c, idx};
  endfunction

  task automatic model_reset();
    m_pend = '{d: '0, c: '0};
    m_show = '{d: '0, c: '0};
    m_pos  = 0;
    m_h    = 0;
    m_hist = {};
    repeat (8) m_hist.push_back(8'h00);
    exp_pfpix = 8'h00;
    exp_trans = 1'b1;
  endtask

  task automatic model_step();
    logic [7:0] shout;
    if (rst) begin
      model_reset();
      return;
    end
    shout     = pix_of(m_show, m_pos);
    exp_pfpix = m_hist[m_h];
    exp_trans = (exp_pfpix[3:0] == 4'h0);
    m_hist.push_front(shout);
    void'(m_hist.pop_back());
    if (!pf_if.PFHST_b || m_pos == 7) begin
      m_show = m_pend;
      m_pos  = 0;
    end else begin
      m_pos++;
    end
    if (pf_if.GFX_LD) m_pend = '{d: pf_if.GFX_D, c: pf_if.COLOR};
    if (!pf_if.PFHST_b) m_h = int'(pf_if.HFINE);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pfpix_model", 32'(pf_if.PFPIX), 32'(exp_pfpix));
    check("pf_trans_model", 32'(pf_if.PF_TRANS), 32'(exp_trans));
  endtask

  task automatic idle_inputs();
    pf_if.PFHST_b = 1'b1;
    pf_if.GFX_LD  = 1'b0;
    pf_if.GFX_D   = '0;
    pf_if.COLOR   = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) tick();
    check("rst_pfpix", 32'(pf_if.PFPIX), 32'h00);
    check("rst_trans", 32'(pf_if.PF_TRANS), 32'h1);
    rst = 1'b0;
  endtask

  // Single tile {0xFF,0x00,0x00,0x80} colour 5, started by a line strobe
  task automatic run_single_tile(input int hf, input bit change_mid);
    do_reset(2);
    pf_if.GFX_D  = 32'hFF00_0080;
    pf_if.COLOR  = 4'h5;
    pf_if.GFX_LD = 1'b1;
    tick();
    pf_if.GFX_LD  = 1'b0;
    pf_if.PFHST_b = 1'b0;
    pf_if.HFINE   = 3'(hf);
    tick();
    pf_if.PFHST_b = 1'b1;
    for (int k = 1; k <= hf + 9; k++) begin
      if (change_mid && k == 3) pf_if.HFINE = 3'd2;
      tick();
      if (k < hf + 2)       check("tile_pre",   32'(pf_if.PFPIX), 32'h00);
      else if (k == hf + 2) check("tile_first", 32'(pf_if.PFPIX), 32'h59);
      else                  check("tile_rest",  32'(pf_if.PFPIX), 32'h58);
    end
  endtask

  initial begin
    rst = 1'b1;
    pf_if.HFINE = 3'd0;
    idle_inputs();
    model_reset();

    // Reset, then no tile data ever loaded: output stays transparent
    do_reset(2);
    for (int k = 0; k < 20; k++) begin
      pf_if.PFHST_b = (k != 5);
      tick();
      check("idle_zero", 32'(pf_if.PFPIX), 32'h00);
    end
    pf_if.PFHST_b = 1'b1;

    // Single tile, no scroll; then 5-cycle scroll with a mid-line HFINE change
    run_single_tile(0, 1'b0);
    run_single_tile(5, 1'b1);

    // Back-to-back tiles, each new GFX_LD colliding with phase 7
    do_reset(2);
    pf_if.HFINE  = 3'd0;
    pf_if.GFX_D  = 32'h0000_00AA;
    pf_if.COLOR  = 4'h1;
    pf_if.GFX_LD = 1'b1;
    tick();
    pf_if.GFX_LD  = 1'b0;
    pf_if.PFHST_b = 1'b0;
    tick();
    pf_if.PFHST_b = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      pf_if.GFX_LD = (j % 8 == 0);
      pf_if.GFX_D  = ((j / 8) % 2 == 1) ? 32'h0000_0055 : 32'h0000_00AA;
      pf_if.COLOR  = ((j / 8) % 2 == 1) ? 4'h2 : 4'h1;
      tick();
      if (j == 10) check("collide_old_tile", 32'(pf_if.PFPIX), 32'h11);
      if (j == 18) check("collide_new_tile0", 32'(pf_if.PFPIX), 32'h20);
      if (j == 19) check("collide_new_tile1", 32'(pf_if.PFPIX), 32'h21);
    end
    idle_inputs();

    // Mid-tile restart at phase 3, then reset in the middle of the line
    do_reset(2);
    pf_if.GFX_D  = 32'h0000_00F0;
    pf_if.COLOR  = 4'h3;
    pf_if.GFX_LD = 1'b1;
    tick();
    pf_if.GFX_LD  = 1'b0;
    pf_if.PFHST_b = 1'b0;
    tick();
    pf_if.PFHST_b = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      pf_if.GFX_LD  = (j == 1);
      pf_if.GFX_D   = 32'h0000_FF00;
      pf_if.COLOR   = 4'h6;
      pf_if.PFHST_b = (j != 4);
      rst           = (j == 8);
      tick();
      if (j == 5) check("restart_last_old", 32'(pf_if.PFPIX), 32'h31);
      if (j == 6) check("restart_first_new", 32'(pf_if.PFPIX), 32'h62);
      if (j == 8) begin
        check("midline_rst_pfpix", 32'(pf_if.PFPIX), 32'h00);
        check("midline_rst_trans", 32'(pf_if.PF_TRANS), 32'h1);
      end
    end
    rst = 1'b0;
    idle_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      pf_if.PFHST_b = ($urandom_range(0, 39) != 0);
      pf_if.HFINE   = 3'($urandom);
      pf_if.GFX_LD  = ($urandom_range(0, 3) == 0);
      pf_if.GFX_D   = $urandom;
      pf_if.COLOR   = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
